// File: rtl/column_carry_resolve_if.sv
// column_carry_resolve_if: frame-capture handshake plus resolved-word stream for column_carry_resolve
interface column_carry_resolve_if #(
  parameter int NUM_COLS = 66,
  parameter int IN_BIT_LEN = 28,
  parameter int WORD_LEN = 16,
  parameter int CARRY_LEN = IN_BIT_LEN - WORD_LEN + 2,
  parameter int IDX_LEN = $clog2(NUM_COLS)
);
  logic in_valid;
  logic in_ready;
  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0] Cin;
  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0] Sin;
  logic out_valid;
  logic out_ready;
  logic [WORD_LEN-1:0] out_data;
  logic [IDX_LEN-1:0] out_index;
  logic out_last;
  logic [CARRY_LEN-1:0] out_carry;
  modport master (
    output in_valid, Cin, Sin, out_ready,
    input in_ready, out_valid, out_data, out_index, out_last, out_carry
  );
  modport slave (
    input in_valid, Cin, Sin, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, out_carry
  );
endinterface

// File: rtl/column_carry_resolve.sv
// column_carry_resolve: captures a carry/sum column frame on bus (valid/ready) and streams it out as normalized WORD_LEN words with final out_carry; clk, sync active-high rst
module column_carry_resolve #(
  parameter int NUM_COLS = 66,
  parameter int IN_BIT_LEN = 28,
  parameter int WORD_LEN = 16,
  parameter int CARRY_LEN = IN_BIT_LEN - WORD_LEN + 2,
  parameter int IDX_LEN = $clog2(NUM_COLS)
) (
  input logic clk,
  input logic rst,
  column_carry_resolve_if.slave bus
);
  localparam int V_LEN = WORD_LEN + CARRY_LEN;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0] cin_r, sin_r;
  logic [IDX_LEN-1:0] k;
  logic [CARRY_LEN-1:0] carry;
  logic [V_LEN-1:0] v;
  logic take, done, load, last;
  assign bus.in_ready = (state == IDLE) & ~rst;
  always_comb begin
    v = V_LEN'(cin_r[k]) + V_LEN'(sin_r[k]) + V_LEN'(carry);
    last = k == IDX_LEN'(NUM_COLS - 1);
    take = bus.in_valid & bus.in_ready;
    done = bus.out_valid & bus.out_ready & bus.out_last;
    load = (state == RUN) & (~bus.out_valid | (bus.out_ready & ~bus.out_last));
    state_n = take ? RUN : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.out_valid <= 1'b0;
      k <= '0;
      carry <= '0;
      bus.out_data <= '0;
      bus.out_index <= '0;
      bus.out_last <= 1'b0;
      bus.out_carry <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        cin_r <= bus.Cin;
        sin_r <= bus.Sin;
        k <= '0;
        carry <= '0;
      end
      if (done) begin
        bus.out_valid <= 1'b0;
        bus.out_last <= 1'b0;
      end else if (load) begin
        bus.out_valid <= 1'b1;
        bus.out_data <= v[WORD_LEN-1:0];
        bus.out_index <= k;
        bus.out_last <= last;
        bus.out_carry <= last ? v[WORD_LEN +: CARRY_LEN] : '0;
        carry <= v[WORD_LEN +: CARRY_LEN];
        k <= last ? '0 : k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_column_carry_resolve.sv
// tb_column_carry_resolve: scoreboard bench for column_carry_resolve at small (4x20) and default (66x28) sizes
module tb_column_carry_resolve;
  localparam int SC = 4;
  localparam int SB = 20;
  localparam int BC = 66;
  localparam int BB = 28;
  typedef struct {
    logic [15:0] d;
    int i;
    logic l;
    logic [13:0] c;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  column_carry_resolve_if #(.NUM_COLS(SC), .IN_BIT_LEN(SB)) s ();
  column_carry_resolve_if b ();
  column_carry_resolve #(.NUM_COLS(SC), .IN_BIT_LEN(SB)) u_s (.clk(clk), .rst(rst), .bus(s));
  column_carry_resolve u_b (.clk(clk), .rst(rst), .bus(b));
  exp_t sq[$];
  exp_t bq[$];
  int npass = 0;
  int ntot = 0;
  int cyc = 0;
  int last_cyc = 0;
  int b_cap = 0;
  int b_beats = 0;
  bit b_rnd = 0;
  bit gap_en = 0;
  bit s_st = 0;
  bit b_st = 0;
  bit b_pv = 0;
  logic [15:0] sd, bd;
  int si, bi;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic mon();
    exp_t e;
    if (s_st) begin
      chk("s_hold_valid", s.out_valid, 1);
      chk("s_hold_data", s.out_data, sd);
      chk("s_hold_idx", s.out_index, si);
    end
    s_st = s.out_valid === 1'b1 && s.out_ready === 1'b0;
    sd = s.out_data;
    si = s.out_index;
    if (s.out_valid === 1'b1 && s.out_ready === 1'b1) begin
      chk("s_beat_expected", sq.size() != 0, 1);
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("s_data", s.out_data, e.d);
        chk("s_index", s.out_index, e.i);
        chk("s_last", s.out_last, e.l);
        if (e.l) chk("s_carry", s.out_carry, e.c);
      end
    end
    if (b_st) begin
      chk("b_hold_valid", b.out_valid, 1);
      chk("b_hold_data", b.out_data, bd);
      chk("b_hold_idx", b.out_index, bi);
    end
    b_st = b.out_valid === 1'b1 && b.out_ready === 1'b0;
    bd = b.out_data;
    bi = b.out_index;
    if (gap_en && last_cyc != 0 && b.out_valid === 1'b1 && !b_pv) begin
      chk("b2b_gap", cyc - last_cyc, 2);
      gap_en = 0;
    end
    b_pv = b.out_valid === 1'b1;
    if (b.out_valid === 1'b1 && b.out_ready === 1'b1) begin
      b_beats++;
      if (b.out_last === 1'b1) last_cyc = cyc + 1;
      chk("b_beat_expected", bq.size() != 0, 1);
      if (bq.size() != 0) begin
        e = bq.pop_front();
        chk("b_data", b.out_data, e.d);
        chk("b_index", b.out_index, e.i);
        chk("b_last", b.out_last, e.l);
        if (e.l) chk("b_carry", b.out_carry, e.c);
      end
    end
  endtask

  task automatic tick();
    mon();
    @(posedge clk);
    cyc++;
    #1;
    if (b_rnd) b.out_ready = $urandom_range(31) != 0;
  endtask

  task automatic s_send(input logic [SC-1:0][SB-1:0] c, input logic [SC-1:0][SB-1:0] sv);
    logic [95:0] tot;
    int n;
    tot = '0;
    for (int k = 0; k < SC; k++) tot = tot + ((96'(c[k]) + 96'(sv[k])) << (16 * k));
    for (int k = 0; k < SC; k++) sq.push_back('{tot[16*k +: 16], k, k == SC - 1, 14'(tot[64 +: 6])});
    s.Cin = c;
    s.Sin = sv;
    s.in_valid = 1'b1;
    for (n = 0; n < 1000 && s.in_ready !== 1'b1; n++) tick();
    chk("s_capture_timeout", n < 1000, 1);
    tick();
    s.in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [BC-1:0][BB-1:0] c, input logic [BC-1:0][BB-1:0] sv);
    logic [1087:0] tot;
    int n;
    tot = '0;
    for (int k = 0; k < BC; k++) tot = tot + ((1088'(c[k]) + 1088'(sv[k])) << (16 * k));
    for (int k = 0; k < BC; k++) bq.push_back('{tot[16*k +: 16], k, k == BC - 1, tot[1056 +: 14]});
    b.Cin = c;
    b.Sin = sv;
    b.in_valid = 1'b1;
    for (n = 0; n < 1000 && b.in_ready !== 1'b1; n++) tick();
    chk("b_capture_timeout", n < 1000, 1);
    b_cap = cyc;
    tick();
    b.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 5000 && (sq.size() != 0 || bq.size() != 0 || s.out_valid === 1'b1 || b.out_valid === 1'b1); n++) tick();
    chk("drain_queue_empty", sq.size() + bq.size(), 0);
  endtask

  initial begin
    logic [SC-1:0][SB-1:0] sc, ss;
    logic [BC-1:0][BB-1:0] bc, bs;
    int n;
    rst = 1'b1;
    s.in_valid = 1'b0;
    s.out_ready = 1'b1;
    s.Cin = '0;
    s.Sin = '0;
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    b.Cin = '0;
    b.Sin = '0;
    tick();
    tick();
    chk("rst_s_in_ready", s.in_ready, 0);
    chk("rst_s_out_valid", s.out_valid, 0);
    chk("rst_s_out_data", s.out_data, 0);
    chk("rst_s_out_index", s.out_index, 0);
    chk("rst_s_out_last", s.out_last, 0);
    chk("rst_s_out_carry", s.out_carry, 0);
    chk("rst_b_out_valid", b.out_valid, 0);
    chk("rst_b_in_ready", b.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_in_ready", s.in_ready, 1);
    chk("post_rst_b_in_ready", b.in_ready, 1);
    sc = '0;
    ss = '0;
    sc[0] = 20'h1;
    ss[0] = 20'h1FFFF;
    ss[1] = 20'hFFFF;
    s_send(sc, ss);
    drain();
    s_send({SC{20'hFFFFF}}, {SC{20'hFFFFF}});
    drain();
    s_send(sc, ss);
    for (n = 0; n < 100 && !(s.out_valid === 1'b1 && s.out_index == 2'd1); n++) tick();
    s.out_ready = 1'b0;
    repeat (3) tick();
    chk("bp_data", s.out_data, 16'h0001);
    chk("bp_index", s.out_index, 1);
    s.out_ready = 1'b1;
    drain();
    last_cyc = 0;
    gap_en = 1;
    b_beats = 0;
    bs = {BC{28'hFFFFFFF}};
    b_send(bs, bs);
    for (int k = 0; k < BC; k++) begin
      bc[k] = 28'($urandom());
      bs[k] = 28'($urandom());
    end
    b_send(bc, bs);
    chk("b2b_in_ready_rise", b_cap, last_cyc);
    chk("b2b_in_ready_low", b.in_ready, 0);
    drain();
    chk("b2b_beats", b_beats, 2 * BC);
    for (int k = 0; k < BC; k++) begin
      bc[k] = 28'($urandom());
      bs[k] = 28'($urandom());
    end
    b_send(bc, bs);
    for (n = 0; n < 100 && !(b.out_valid === 1'b1 && b.out_index == 7'd3); n++) tick();
    b.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready_comb", b.in_ready, 0);
    bq.delete();
    tick();
    b_st = 0;
    chk("midrst_out_valid", b.out_valid, 0);
    chk("midrst_in_ready", b.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", b.in_ready, 1);
    b.out_ready = 1'b1;
    repeat (3) tick();
    chk("midrst_no_beats", b.out_valid, 0);
    bc = '0;
    bs = '0;
    bs[0] = 28'd5;
    b_send(bc, bs);
    drain();
    b_rnd = 1;
    repeat (1000) begin
      for (int k = 0; k < BC; k++) begin
        bc[k] = 28'($urandom());
        bs[k] = 28'($urandom());
      end
      b_send(bc, bs);
    end
    b_rnd = 0;
    b.out_ready = 1'b1;
    drain();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
